// File: rtl/id_stage_hz.sv
// id_stage_hz: MIPS instruction-decode stage with control decoder, register
// file, sign extension, load-use hazard detection and a clocked ID/EX
// register carrying a valid bit.
// Optional build macro: WB_BYPASS_EN -- when defined, a write-back to the
// register being read is returned on the read port in the same cycle.
module id_stage_hz #(
   parameter int DATA_W   = 32,
   parameter int REG_AW   = 5,
   parameter int NUM_REGS = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       if_id_instr,
   input  logic [DATA_W-1:0] if_id_npc,
   input  logic              if_id_valid,
   input  logic              ex_flush,
   input  logic [REG_AW-1:0] wb_rd,
   input  logic              wb_regwrite,
   input  logic [DATA_W-1:0] wb_writedata,
   output logic              stall,
   output logic              id_ex_valid,
   output logic [1:0]        wb_ctlout,
   output logic [2:0]        m_ctlout,
   output logic              regdst,
   output logic              alusrc,
   output logic [1:0]        aluop,
   output logic [DATA_W-1:0] npcout,
   output logic [DATA_W-1:0] rdata1out,
   output logic [DATA_W-1:0] rdata2out,
   output logic [DATA_W-1:0] s_extendout,
   output logic [REG_AW-1:0] instrout_2521,
   output logic [REG_AW-1:0] instrout_2016,
   output logic [REG_AW-1:0] instrout_1511
);

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;

   // One extra bit so NUM_REGS == 2**REG_AW is representable.
   localparam logic [REG_AW:0] REG_LIMIT = (REG_AW+1)'(NUM_REGS);

   logic [5:0]        opcode;
   logic [REG_AW-1:0] rs, rt, rd;
   logic [DATA_W-1:0] s_extend;
   logic [DATA_W-1:0] rdata1, rdata2;

   logic              dec_regdst;
   logic              dec_alusrc;
   logic [1:0]        dec_aluop;
   logic [2:0]        dec_m;
   logic [1:0]        dec_wb;

   logic              uses_rt;
   logic              hazard;
   logic              bubble;
   logic              write_ok;

   logic [DATA_W-1:0] regs [NUM_REGS];

   assign opcode   = if_id_instr[31:26];
   assign rs       = REG_AW'(if_id_instr[25:21]);
   assign rt       = REG_AW'(if_id_instr[20:16]);
   assign rd       = REG_AW'(if_id_instr[15:11]);
   assign s_extend = {{(DATA_W-16){if_id_instr[15]}}, if_id_instr[15:0]};

   // Main control decoder: {regdst, aluop, alusrc} / M / WB from the opcode.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves one unassigned, which would infer a latch.
      dec_regdst = 1'b0;
      dec_aluop  = 2'b00;
      dec_alusrc = 1'b0;
      dec_m      = 3'b000;
      dec_wb     = 2'b00;
      case (opcode)
         OP_RTYPE: begin dec_regdst = 1'b1; dec_aluop = 2'b10; dec_wb = 2'b10; end
         OP_LW:    begin dec_alusrc = 1'b1; dec_m = 3'b010; dec_wb = 2'b11; end
         OP_SW:    begin dec_alusrc = 1'b1; dec_m = 3'b001; end
         OP_BEQ:   begin dec_aluop = 2'b01; dec_m = 3'b100; end
         default:  ;
      endcase
   end

   // Register 0 and addresses beyond NUM_REGS are never written.
   assign write_ok = wb_regwrite && (wb_rd != '0) && ({1'b0, wb_rd} < REG_LIMIT);

   // Register file write port; whole file clears on reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: the storage array is reset explicitly so reads after reset return 0 rather than X.
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else if (write_ok) begin
         // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of block order.
         regs[wb_rd] <= wb_writedata;
      end
   end

   function automatic logic [DATA_W-1:0] read_reg(input logic [REG_AW-1:0] addr);
      logic [DATA_W-1:0] v;
      v = '0;
      if ((addr != '0) && ({1'b0, addr} < REG_LIMIT)) begin
`ifdef WB_BYPASS_EN
         if (wb_regwrite && (wb_rd == addr)) v = wb_writedata;
         else                                v = regs[addr];
`else
         v = regs[addr];
`endif
      end
      return v;
   endfunction

   // Combinational read ports on rs and rt.
   always_comb begin
      rdata1 = read_reg(rs);
      rdata2 = read_reg(rt);
   end

   // Load-use detection against the load currently sitting in ID/EX.
   always_comb begin
      uses_rt = (opcode == OP_RTYPE) || (opcode == OP_SW) || (opcode == OP_BEQ);
      hazard  = id_ex_valid && m_ctlout[1] && (instrout_2016 != '0) &&
                ((instrout_2016 == rs) || (uses_rt && (instrout_2016 == rt)));
      // A flushed instruction is discarded, so there is nothing to hold.
      stall   = hazard && if_id_valid && !ex_flush;
      bubble  = ex_flush || stall || !if_id_valid;
   end

   // ID/EX pipeline register: bubble on flush, stall or empty IF/ID.
   always_ff @(posedge clk or posedge rst) begin
      if (rst || bubble) begin
         id_ex_valid   <= 1'b0;
         regdst        <= 1'b0;
         aluop         <= 2'b00;
         alusrc        <= 1'b0;
         m_ctlout      <= 3'b000;
         wb_ctlout     <= 2'b00;
         npcout        <= '0;
         rdata1out     <= '0;
         rdata2out     <= '0;
         s_extendout   <= '0;
         instrout_2521 <= '0;
         instrout_2016 <= '0;
         instrout_1511 <= '0;
      end else begin
         id_ex_valid   <= 1'b1;
         regdst        <= dec_regdst;
         aluop         <= dec_aluop;
         alusrc        <= dec_alusrc;
         m_ctlout      <= dec_m;
         wb_ctlout     <= dec_wb;
         npcout        <= if_id_npc;
         rdata1out     <= rdata1;
         rdata2out     <= rdata2;
         s_extendout   <= s_extend;
         instrout_2521 <= rs;
         instrout_2016 <= rt;
         instrout_1511 <= rd;
      end
   end

endmodule
